div_sequencer: RTL and testbench

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_sequencer.sv | 152 +++++++++++++++
 tb/tb_div_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Latency: XLEN+1 cycles from start accepted in IDLE to done; 1 cycle for divide-by-zero/overflow.
// Backpressure: stall holds the front of the pipe while the op is outstanding; flush aborts it.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic            want_rem_q;

  // Operand decode, evaluated only when an op is accepted in IDLE.
  logic            is_signed;
  logic            want_rem;
  logic            sign1;
  logic            sign2;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic            div_zero;
  logic            overflow;
  logic            special;
  logic [XLEN-1:0] special_res;

  // funct3[2] only separates the divide group from multiplies upstream.
  logic unused_funct3;
  assign unused_funct3 = funct3[2];

  always_comb begin
    is_signed   = ~funct3[0];
    want_rem    = funct3[1];
    sign1       = is_signed & rs1_val[XLEN-1];
    sign2       = is_signed & rs2_val[XLEN-1];
    mag1        = sign1 ? (~rs1_val + 1'b1) : rs1_val;
    mag2        = sign2 ? (~rs2_val + 1'b1) : rs2_val;
    div_zero    = (rs2_val == '0);
    overflow    = is_signed & (rs1_val == MOST_NEG) & (rs2_val == '1);
    special     = div_zero | overflow;
    special_res = '0;
    if (div_zero)
      special_res = want_rem ? rs1_val : '1;
    else if (!want_rem)
      special_res = rs1_val;
  end

  // One restoring step: the trial difference is XLEN+1 wide, so its MSB is the borrow.
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic            fits;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] final_res;

  always_comb begin
    shifted   = {rem_q, quo_q[XLEN-1]};
    trial     = shifted - {1'b0, dvs_q};
    fits      = ~trial[XLEN];
    rem_nxt   = fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    quo_nxt   = {quo_q[XLEN-2:0], fits};
    quo_fix   = neg_quo_q ? (~quo_nxt + 1'b1) : quo_nxt;
    rem_fix   = neg_rem_q ? (~rem_nxt + 1'b1) : rem_nxt;
    final_res = want_rem_q ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      done       <= 1'b0;
      result     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      want_rem_q <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (special) begin
                state  <= DONE;
                done   <= 1'b1;
                result <= special_res;
              end else begin
                state      <= CALC;
                count      <= CW'(XLEN);
                rem_q      <= '0;
                quo_q      <= mag1;
                dvs_q      <= mag2;
                neg_quo_q  <= sign1 ^ sign2;
                neg_rem_q  <= sign1;
                want_rem_q <= want_rem;
              end
            end
          end
          CALC: begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            count <= count - 1'b1;
            if (count == CW'(1)) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= final_res;
            end
          end
          DONE: begin
            // start here belongs to the retiring instruction.
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy  = (state == CALC);
  assign stall = start & ~done & ~flush;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: a driver queues expected results and done cycles,
// a negedge monitor pops and compares whenever done is seen.
module tb_div_sequencer;

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  div_sequencer #(.XLEN(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .flush   (flush),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] last_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done at cycle %0d: result %h, no op outstanding", cyc, result);
      end else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("done_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  // Issue one op at a negedge, hold start until done, then release in the following IDLE cycle.
  task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input bit scramble);
    bit got;
    funct3  = f;
    rs1_val = a;
    rs2_val = b;
    start   = 1'b1;
    sb.push_back('{res: exp, at: cyc + lat});
    last_res = exp;
    #1 check("stall_issue", 32'(stall), 32'd1);
    got = 1'b0;
    for (int k = 0; k < lat + 5 && !got; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
      end else begin
        check("stall_held", 32'(stall), 32'd1);
        if (scramble && k == 5) begin
          rs1_val = $urandom;
          rs2_val = $urandom;
          funct3  = {1'b1, f[1:0] ^ 2'b11};
        end
      end
    end
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s timeout: no done within %0d cycles, expected at %0d", name, lat + 5, lat);
      void'(sb.pop_back());
    end else begin
      check("stall_at_done", 32'(stall), 32'd0);
      if (lat == 1) check("busy_special", 32'(busy), 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected under 20000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    flush   = 1'b0;
    funct3  = 3'b000;
    rs1_val = '0;
    rs2_val = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",   32'(busy),   32'd0);
    check("reset_done",   32'(done),   32'd0);
    check("reset_result", result,      32'd0);
    check("reset_stall",  32'(stall),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic unsigned, back-to-back.
    do_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    do_op("remu_100_7", F_REMU, 32'd100, 32'd7, 32'd2,  33, 1'b0);
    // Signed sign rules; the first one has its operands scrambled mid-CALC.
    do_op("div_m7_2",   F_DIV, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33, 1'b1);
    do_op("rem_m7_2",   F_REM, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33, 1'b0);
    do_op("div_7_m2",   F_DIV, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0);
    do_op("div_m7_m2",  F_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         33, 1'b0);
    do_op("rem_m7_m2",  F_REM, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33, 1'b0);
    do_op("rem_m100_7", F_REM, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 33, 1'b0);
    do_op("rem_100_m7", F_REM, 32'd100,       32'hFFFF_FFF9, 32'd2,         33, 1'b0);
    // Divide by zero and signed overflow, single-cycle.
    do_op("divu_by0",   F_DIVU, 32'h0000_1234, 32'd0,        32'hFFFF_FFFF, 1, 1'b0);
    do_op("remu_by0",   F_REMU, 32'h0000_1234, 32'd0,        32'h0000_1234, 1, 1'b0);
    do_op("div_by0",    F_DIV,  32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFFF, 1, 1'b0);
    do_op("rem_by0",    F_REM,  32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 1, 1'b0);
    do_op("div_ovf",    F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    do_op("rem_ovf",    F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1, 1'b0);
    // Full-width unsigned cases, including the pattern that is overflow only when signed.
    do_op("divu_big",   F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        33, 1'b0);
    do_op("remu_big",   F_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b0);
    do_op("divu_ff_16", F_DIVU, 32'hFFFF_FFFF, 32'h10,       32'h0FFF_FFFF, 33, 1'b0);
    do_op("remu_ff_16", F_REMU, 32'hFFFF_FFFF, 32'h10,       32'h0000_000F, 33, 1'b0);
    do_op("divu_5_10",  F_DIVU, 32'd5,        32'd10,        32'd0,        33, 1'b0);
    do_op("remu_5_10",  F_REMU, 32'd5,        32'd10,        32'd5,        33, 1'b0);

    // Flush in CALC cycle 10: no done, busy drops, result holds.
    funct3  = F_DIVU;
    rs1_val = 32'd100;
    rs2_val = 32'd7;
    start   = 1'b1;
    repeat (10) @(negedge clk);
    check("busy_calc", 32'(busy), 32'd1);
    flush = 1'b1;
    #1 check("stall_flush", 32'(stall), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    check("busy_after_flush", 32'(busy), 32'd0);
    check("done_after_flush", 32'(done), 32'd0);
    check("result_hold",      result,    last_res);
    do_op("divu_9_3",   F_DIVU, 32'd9,  32'd3, 32'd3, 33, 1'b0);
    do_op("divu_9_3b",  F_DIVU, 32'd9,  32'd3, 32'd3, 33, 1'b0);
    do_op("remu_10_4",  F_REMU, 32'd10, 32'd4, 32'd2, 33, 1'b0);

    // Flush dominates start in IDLE.
    funct3  = F_DIVU;
    rs1_val = 32'd50;
    rs2_val = 32'd5;
    start   = 1'b1;
    flush   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("busy_flush_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("busy_flush_idle2", 32'(busy), 32'd0);

    // Reset mid-CALC, start held through and after it.
    funct3  = F_DIV;
    rs1_val = 32'hFFFF_FFF9;
    rs2_val = 32'd2;
    start   = 1'b1;
    repeat (6) @(negedge clk);
    check("busy_pre_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_result", result,    32'd0);
    rst = 1'b0;
    do_op("div_after_rst", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
